serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal values 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand request.
REQ-005 in_ready  output  1  block idle; can accept operands.
REQ-006 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Cin  input  1  carry-in in add mode; borrow-in in subtract mode.
REQ-009 mode  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 Sum  output  WIDTH  result: sum or difference.
REQ-013 Cout  output  1  carry-out in add mode; borrow-out in subtract mode.
REQ-014 Ovf  output  1  signed (two's complement) overflow flag.

Function
REQ-015 States SHALL be: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 Operand acceptance: when in_valid=1 in IDLE, the block SHALL latch A, B, Cin and mode on that edge, then go to RUN.
REQ-019 Operand preparation on acceptance:
- add mode: B latched as is; carry flop set to Cin.
- subtract mode: B latched inverted; carry flop set to ~Cin.
REQ-020 Each RUN cycle SHALL process one bit, LSB first, with a single 1-bit full adder:
- sum bit = a ^ b ^ c;
- carry = majority(a, b, c);
- sum bit shifted into the result register from the MSB side;
- operand registers shifted right by one.
REQ-021 A bit counter SHALL count WIDTH RUN cycles. After the WIDTH-th bit the block SHALL enter DONE.
REQ-022 Latency: out_valid SHALL assert exactly WIDTH+1 rising edges after the accepting edge.
REQ-023 Cout in add mode SHALL be the final carry.
REQ-024 Cout in subtract mode SHALL be the inverted final carry, i.e. 1 iff A < B + Cin (unsigned).
REQ-025 Ovf SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-026 Arithmetic: {Cout,Sum} SHALL equal A+B+Cin (add) or the WIDTH-bit result of A-B-Cin with Cout as borrow (subtract), for all inputs.
REQ-027 Sum, Cout and Ovf SHALL hold stable while out_valid=1. They SHALL hold their last value in IDLE until the next result.
REQ-028 In DONE with out_ready=1, the block SHALL return to IDLE on that edge. With out_ready=0 it SHALL stay in DONE indefinitely.
REQ-029 in_valid SHALL be ignored in RUN and DONE. Operand inputs changing during RUN SHALL NOT affect the result.
REQ-030 Simultaneous events: out_ready=1 and in_valid=1 in the same DONE cycle SHALL complete the handshake only. New operands are accepted at the earliest in the following IDLE cycle.
REQ-031 WIDTH=2 and WIDTH=32 SHALL function without change to the state machine.

Reset
REQ-032 On rst=1 the block SHALL asynchronously enter IDLE.
REQ-033 Reset values: in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, counter=0, carry flop=0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation and discard the result. No out_valid pulse SHALL follow deassertion.
REQ-035 After rst deasserts, the first clock edge SHALL be able to accept operands.

Verification
REQ-036 Add wrap: WIDTH=4, mode=0, A=4'hF, B=4'h1, Cin=0 -> after 5 edges Sum=4'h0, Cout=1, Ovf=0.
REQ-037 Subtract with borrow: mode=1, A=4'h3, B=4'h5, Cin=0 -> Sum=4'hE, Cout=1, Ovf=0; repeat with Cin=1 -> Sum=4'hD, Cout=1.
REQ-038 Signed overflow: mode=1, A=4'h8, B=4'h1, Cin=0 -> Sum=4'h7, Cout=0, Ovf=1; mode=0, A=4'h7, B=4'h1 -> Sum=4'h8, Ovf=1.
REQ-039 Exhaustive sweep: all mode x Cin x A x B (1024 cases, WIDTH=4) checked against a behavioural model; out_ready held 1.
REQ-040 Backpressure and ignore: out_ready=0 for 3 cycles in DONE -> outputs stable and out_valid held; in_valid pulsed during RUN -> no second operation; result unchanged.
REQ-041 Reset mid-operation: rst pulsed on the 2nd RUN cycle -> in_ready=1, out_valid=0, Sum=0 immediately; the next operation completes correctly.

Source files
------------

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Purpose  : Bit-serial adder/subtractor, one full-adder step per clock, LSB
//            first, with carry/borrow-out and signed overflow flags.
// Revision : 1.0
// ============================================================================
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH);
   localparam logic [CW-1:0] C_MSB  = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_c;
   logic             r_cmsb;
   logic             r_mode;
   logic             r_cout;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_sbit;
   logic             w_cnext;

   assign w_sbit  = r_a[0] ^ r_b[0] ^ r_c;
   assign w_cnext = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

   // RUN spends WIDTH cycles on bits and one final cycle committing the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_c         <= 1'b0;
         r_cmsb      <= 1'b0;
         r_mode      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= A;
                  r_b        <= mode ? ~B : B;
                  r_c        <= mode ? ~Cin : Cin;
                  r_mode     <= mode;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               if (r_cnt == C_LAST) begin
                  r_sum       <= r_res;
                  r_cout      <= r_c ^ r_mode;
                  r_ovf       <= r_c ^ r_cmsb;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_res <= {w_sbit, r_res[WIDTH-1:1]};
                  r_a   <= r_a >> 1;
                  r_b   <= r_b >> 1;
                  r_c   <= w_cnext;
                  if (r_cnt == C_MSB) begin
                     r_cmsb <= r_c;
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Sum       = r_sum;
   assign Cout      = r_cout;
   assign Ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Purpose  : Self-checking bench for serial_addsub against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_serial_addsub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Ovf       (Ovf)
   );

   // Result packed as {Cout, Ovf, Sum}, computed with plain integer arithmetic.
   function automatic logic [W+1:0] model(input int a, input int b, input int cin, input int md);
      int t, sa, sb, st;
      logic co, ov;
      logic [W-1:0] s;
      sa = (a >= 2**(W-1)) ? a - 2**W : a;
      sb = (b >= 2**(W-1)) ? b - 2**W : b;
      if (md == 0) begin
         t  = a + b + cin;
         co = (t >= 2**W);
         st = sa + sb + cin;
      end else begin
         t  = a - b - cin;
         co = (t < 0);
         st = sa - sb - cin;
      end
      s  = t[W-1:0];
      ov = (st > 2**(W-1) - 1) || (st < -(2**(W-1)));
      return {co, ov, s};
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic md, output int lat, output logic [W+1:0] got);
      A = a; B = b; Cin = ci; mode = md; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); mode = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      got = {Cout, Ovf, Sum};
   endtask

   task automatic test_reset;
      int lat;
      logic [W+1:0] got;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Cin = 1'b0; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({in_ready, out_valid, Cout, Ovf, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0})
         $display("FAIL reset_state got rdy=%b vld=%b co=%b ov=%b sum=%h exp 1 0 0 0 0",
                  in_ready, out_valid, Cout, Ovf, Sum);
      else n_pass++;
      rst = 1'b0;
      run_op(4'h6, 4'h3, 1'b1, 1'b0, lat, got);
      n_total++;
      if (got !== model(6, 3, 1, 0) || lat != W + 1)
         $display("FAIL first_after_reset got %b lat %0d exp %b lat %0d", got, lat, model(6, 3, 1, 0), W + 1);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [5] = '{4'hF, 4'h3, 4'h3, 4'h8, 4'h7};
      logic [W-1:0] tb [5] = '{4'h1, 4'h5, 4'h5, 4'h1, 4'h1};
      logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic         tm [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W+1:0] te [5] = '{6'b10_0000, 6'b10_1110, 6'b10_1101, 6'b01_0111, 6'b01_1000};
      int lat;
      logic [W+1:0] got;
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], tc[i], tm[i], lat, got);
         n_total++;
         if (got !== te[i])
            $display("FAIL directed_%0d got {co,ov,sum}=%b exp %b", i, got, te[i]);
         else n_pass++;
         n_total++;
         if (lat != W + 1)
            $display("FAIL latency_%0d got %0d exp %0d", i, lat, W + 1);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exhaustive;
      int lat;
      logic [W+1:0] got, exp_v;
      out_ready = 1'b1;
      for (int md = 0; md < 2; md++)
         for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 2**W; a++)
               for (int b = 0; b < 2**W; b++) begin
                  run_op(W'(a), W'(b), 1'(ci), 1'(md), lat, got);
                  exp_v = model(a, b, ci, md);
                  n_total++;
                  if (got !== exp_v || lat != W + 1)
                     $display("FAIL sweep m=%0d c=%0d a=%h b=%h got %b lat %0d exp %b lat %0d",
                              md, ci, a, b, got, lat, exp_v, W + 1);
                  else n_pass++;
                  @(posedge clk); #1;
               end
   endtask

   task automatic test_backpressure;
      int lat, a, b, ci, md;
      logic [W+1:0] got, exp_v;
      for (int it = 0; it < 4; it++) begin
         a = $urandom_range(2**W - 1); b = $urandom_range(2**W - 1);
         ci = $urandom_range(1); md = $urandom_range(1);
         exp_v = model(a, b, ci, md);
         out_ready = 1'b0;
         A = W'(a); B = W'(b); Cin = 1'(ci); mode = 1'(md); in_valid = 1'b1;
         @(posedge clk); #1;
         A = ~A; B = ~B;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 50) begin
            in_valid = (lat < 2);
            @(posedge clk); #1;
            lat++;
         end
         in_valid = 1'b0;
         got = {Cout, Ovf, Sum};
         n_total++;
         if (got !== exp_v || lat != W + 1)
            $display("FAIL bp_result got %b lat %0d exp %b lat %0d", got, lat, exp_v, W + 1);
         else n_pass++;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_total++;
            if ({out_valid, in_ready, Cout, Ovf, Sum} !== {1'b1, 1'b0, exp_v})
               $display("FAIL bp_hold_%0d got vld=%b rdy=%b %b exp 1 0 %b",
                        k, out_valid, in_ready, {Cout, Ovf, Sum}, exp_v);
            else n_pass++;
         end
         // Handshake and new request on the same edge: only the handshake happens.
         out_ready = 1'b1; in_valid = 1'b1; A = W'($urandom); B = W'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         n_total++;
         if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_handshake got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if ({in_ready, Cout, Ovf, Sum} !== {1'b1, exp_v})
            $display("FAIL idle_hold got rdy=%b %b exp 1 %b", in_ready, {Cout, Ovf, Sum}, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      int lat, a, b;
      logic [W+1:0] got, exp_v;
      logic seen;
      out_ready = 1'b1;
      run_op(4'h5, 4'h2, 1'b0, 1'b0, lat, got);
      @(posedge clk); #1;
      A = 4'h9; B = 4'h4; Cin = 1'b1; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_total++;
      if ({in_ready, out_valid, Cout, Ovf, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0})
         $display("FAIL reset_mid got rdy=%b vld=%b co=%b ov=%b sum=%h exp 1 0 0 0 0",
                  in_ready, out_valid, Cout, Ovf, Sum);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0)
         $display("FAIL reset_no_pulse got out_valid pulse=%b exp 0", seen);
      else n_pass++;
      a = $urandom_range(2**W - 1); b = $urandom_range(2**W - 1);
      exp_v = model(a, b, 1, 1);
      run_op(W'(a), W'(b), 1'b1, 1'b1, lat, got);
      n_total++;
      if (got !== exp_v || lat != W + 1)
         $display("FAIL after_reset_op got %b lat %0d exp %b lat %0d", got, lat, exp_v, W + 1);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int lat, a, b, ci, md;
      logic [W+1:0] got, exp_v;
      out_ready = 1'b1;
      for (int it = 0; it < 20; it++) begin
         a = $urandom_range(2**W - 1); b = $urandom_range(2**W - 1);
         ci = $urandom_range(1); md = $urandom_range(1);
         exp_v = model(a, b, ci, md);
         n_total++;
         if (in_ready !== 1'b1)
            $display("FAIL b2b_ready_%0d got %b exp 1", it, in_ready);
         else n_pass++;
         run_op(W'(a), W'(b), 1'(ci), 1'(md), lat, got);
         n_total++;
         if (got !== exp_v || lat != W + 1)
            $display("FAIL b2b_%0d got %b lat %0d exp %b lat %0d", it, got, lat, exp_v, W + 1);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_exhaustive;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
